// File: rtl/dpdm_line_driver.sv
// USB LS/FS DP/DM line driver: picks one of NUM_SRC NRZI bit sources and frames it with SYNC and EOP.
// Optional DPDM_IDLE_J_EN: drives J when idle and exports line_oe for a non-tristate PHY.
module dpdm_line_driver #(
  parameter int                  NUM_SRC        = 2,
  parameter int                  SYNC_LEN       = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN   = 8'b0010_1010,
  parameter int                  FIFO_DEPTH     = 16,
  parameter int                  EOP_SE0_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_bit,
  input  logic [NUM_SRC-1:0] src_valid,
  output logic               src_ready,
  input  logic               err_clr,
  output logic               DP,
  output logic               DM,
  output logic               busy,
  output logic               out_done,
  output logic               err_drop
`ifdef DPDM_IDLE_J_EN
  ,
  output logic               line_oe
`endif
);

  localparam int IW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SCW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < SYNC_LEN + 1) begin : g_depth_check
    $error("dpdm_line_driver: FIFO_DEPTH must be >= SYNC_LEN+1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PACKET, S_DRAIN, S_EOP_SE0, S_EOP_J, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    act_idx_q, sel_idx, cur_idx;
  logic             sel_any, cur_valid, cur_bit;
  logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [2:0]       eop_cnt_q, eop_cnt_d;
  logic             end_q, end_d;
  logic             wr_en, rd_en, fifo_rd;
  logic             fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNW-1:0]   cnt_q;
  logic             line_vld_p0, line_bit_p0, line_se0_p0;
  logic             line_vld_p1, line_bit_p1, line_se0_p1;
  logic             busy_d, done_d, err_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fixed-priority pick of the source that opens a packet; lowest index wins.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        sel_idx = IW'(i);
        sel_any = 1'b1;
      end
    end
  end

  assign cur_idx   = (state_q == S_IDLE) ? sel_idx : act_idx_q;
  assign cur_valid = src_valid[cur_idx];
  assign cur_bit   = src_bit[cur_idx];
  assign fifo_rd   = fifo_mem[rd_ptr_q];
  assign src_ready = (state_q == S_IDLE) || (state_q == S_SYNC) || (state_q == S_PACKET);
  assign err_set   = cur_valid && !src_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sel_any) state_d = S_SYNC;
      S_SYNC:    if (sync_cnt_q == SCW'(SYNC_LEN - 1))
                   state_d = (cur_valid && !end_q) ? S_PACKET : S_DRAIN;
      S_PACKET:  if (!cur_valid) state_d = S_DRAIN;
      S_DRAIN:   if (cnt_q == '0) state_d = S_EOP_SE0;
      S_EOP_SE0: if (eop_cnt_q == 3'(EOP_SE0_CYCLES - 1)) state_d = S_EOP_J;
      S_EOP_J:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Each state computes the level shown on the line during the following cycle.
  always_comb begin
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    sync_cnt_d  = sync_cnt_q;
    eop_cnt_d   = eop_cnt_q;
    end_d       = end_q;
    line_vld_p0 = line_vld_p1;
    line_bit_p0 = line_bit_p1;
    line_se0_p0 = line_se0_p1;
    busy_d      = busy;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        sync_cnt_d  = '0;
        eop_cnt_d   = '0;
        end_d       = 1'b0;
        line_vld_p0 = 1'b0;
        if (sel_any) begin
          wr_en       = 1'b1;
          line_vld_p0 = 1'b1;
          line_se0_p0 = 1'b0;
          line_bit_p0 = SYNC_PATTERN[0];
          busy_d      = 1'b1;
        end
      end
      S_SYNC: begin
        wr_en = cur_valid && !end_q;
        if (!cur_valid) end_d = 1'b1;
        if (sync_cnt_q != SCW'(SYNC_LEN - 1)) begin
          sync_cnt_d  = sync_cnt_q + 1'b1;
          line_bit_p0 = SYNC_PATTERN[sync_cnt_q + SCW'(1)];
        end else begin
          rd_en       = 1'b1;
          line_bit_p0 = fifo_rd;
        end
      end
      S_PACKET: begin
        wr_en       = cur_valid;
        rd_en       = 1'b1;
        line_bit_p0 = fifo_rd;
      end
      S_DRAIN: begin
        if (cnt_q != '0) begin
          rd_en       = 1'b1;
          line_bit_p0 = fifo_rd;
        end else begin
          line_se0_p0 = 1'b1;
        end
      end
      S_EOP_SE0: begin
        if (eop_cnt_q != 3'(EOP_SE0_CYCLES - 1)) begin
          eop_cnt_d = eop_cnt_q + 1'b1;
        end else begin
          line_se0_p0 = 1'b0;
          line_bit_p0 = 1'b1;
        end
      end
      S_EOP_J: begin
        line_vld_p0 = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end
      S_DONE:  line_vld_p0 = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_idx_q   <= '0;
      sync_cnt_q  <= '0;
      eop_cnt_q   <= '0;
      end_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      line_vld_p1 <= 1'b0;
      busy        <= 1'b0;
      out_done    <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && sel_any) act_idx_q <= sel_idx;
      sync_cnt_q  <= sync_cnt_d;
      eop_cnt_q   <= eop_cnt_d;
      end_q       <= end_d;
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      line_vld_p1 <= line_vld_p0;
      busy        <= busy_d;
      out_done    <= done_d;
      if (err_set)      err_drop <= 1'b1;
      else if (err_clr) err_drop <= 1'b0;
    end
  end

  // Output stage: buffered bits and line levels carry no reset; line_vld_p1 masks them.
  always_ff @(posedge clock) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= cur_bit;
    line_bit_p1 <= line_bit_p0;
    line_se0_p1 <= line_se0_p0;
  end

`ifdef DPDM_IDLE_J_EN
  assign DP      = line_vld_p1 ? (line_bit_p1 & ~line_se0_p1) : 1'b1;
  assign DM      = line_vld_p1 ? (~line_bit_p1 & ~line_se0_p1) : 1'b0;
  assign line_oe = line_vld_p1;
`else
  assign DP = line_vld_p1 ? (line_bit_p1 & ~line_se0_p1) : 1'bz;
  assign DM = line_vld_p1 ? (~line_bit_p1 & ~line_se0_p1) : 1'bz;
`endif

endmodule

// File: tb/tb_dpdm_line_driver.sv
// Directed bench for dpdm_line_driver: three configurations share stimulus, one is checked per test.
// Pull-ups on DP/DM make a released (zz) line read back as 2'b11.
module tb_dpdm_line_driver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] src_bit, src_valid;
  logic       err_clr;
  wire        dp0, dm0, dp1, dm1, dp2, dm2;
  wire  [2:0] rdy_w, busy_w, done_w, err_w;

  pullup (dp0);
  pullup (dm0);
  pullup (dp1);
  pullup (dm1);
  pullup (dp2);
  pullup (dm2);

  always #5 clock = ~clock;

  dpdm_line_driver u_dut0 (
    .clock(clock), .reset_n(reset_n), .src_bit(src_bit), .src_valid(src_valid),
    .src_ready(rdy_w[0]), .err_clr(err_clr), .DP(dp0), .DM(dm0),
    .busy(busy_w[0]), .out_done(done_w[0]), .err_drop(err_w[0]));

  dpdm_line_driver #(.FIFO_DEPTH(9)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .src_bit(src_bit), .src_valid(src_valid),
    .src_ready(rdy_w[1]), .err_clr(err_clr), .DP(dp1), .DM(dm1),
    .busy(busy_w[1]), .out_done(done_w[1]), .err_drop(err_w[1]));

  dpdm_line_driver #(.SYNC_LEN(32), .SYNC_PATTERN(32'h2AAA_AAAA), .FIFO_DEPTH(33),
                     .EOP_SE0_CYCLES(3)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .src_bit(src_bit), .src_valid(src_valid),
    .src_ready(rdy_w[2]), .err_clr(err_clr), .DP(dp2), .DM(dm2),
    .busy(busy_w[2]), .out_done(done_w[2]), .err_drop(err_w[2]));

  localparam int          S_LEN [3] = '{8, 8, 32};
  localparam int          E_LEN [3] = '{2, 2, 3};
  localparam logic [31:0] PAT   [3] = '{32'h0000_002A, 32'h0000_002A, 32'h2AAA_AAAA};

  int         errors = 0;
  int         checks = 0;
  int         cur_sel = 0;
  logic [1:0] line_m;

  always_comb begin
    case (cur_sel)
      1:       line_m = {dp1, dm1};
      2:       line_m = {dp2, dm2};
      default: line_m = {dp0, dm0};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // J=10, K=01, SE0=00, released=11 (pulled up)
  function automatic logic [1:0] exp_line(int sel, int n, logic [63:0] data, int j);
    int s = S_LEN[sel];
    int e = E_LEN[sel];
    logic [31:0] pat = PAT[sel];
    if (j >= 1 && j <= s)  return pat[j-1] ? 2'b10 : 2'b01;
    if (j > s && j <= s+n) return data[j-s-1] ? 2'b10 : 2'b01;
    if (j > s+n && j <= s+n+e) return 2'b00;
    if (j == s+n+e+1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic wait_idle();
    int quiet = 0;
    for (int k = 0; k < 200 && quiet < 3; k++) begin
      @(negedge clock);
      quiet = (busy_w != 3'b000) ? 0 : quiet + 1;
    end
    check("idle_wait", 32'(quiet >= 3), 32'd1);
  endtask

  task automatic prep();
    src_valid = '0;
    src_bit   = '0;
    wait_idle();
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
  endtask

  // mode 0: src0 only; 1: src1 also valid (inverted bits, 3 cycles longer); 2: src0 re-asserts in EOP
  task automatic run_pkt(input string name, input int sel, input int n, input logic [63:0] data,
                         input int mode);
    int s = S_LEN[sel];
    int e = E_LEN[sel];
    int rdy_lim = (n > s) ? n : s;
    int j;
    cur_sel = sel;
    for (int c = 0; c < s + n + e + 3; c++) begin
      src_valid = '0;
      src_bit   = '0;
      if (c < n) begin
        src_valid[0] = 1'b1;
        src_bit[0]   = data[c];
      end
      if (mode == 1 && c < n + 3) begin
        src_valid[1] = 1'b1;
        src_bit[1]   = (c < n) ? ~data[c] : 1'b1;
      end
      if (mode == 2 && c == s + n + 1) src_valid[0] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      j = c + 1;
      check($sformatf("%s line j=%0d", name, j), 32'(line_m), 32'(exp_line(sel, n, data, j)));
      check($sformatf("%s busy j=%0d", name, j), 32'(busy_w[sel]), 32'(j <= s+n+e+1));
      check($sformatf("%s done j=%0d", name, j), 32'(done_w[sel]), 32'(j == s+n+e+2));
      check($sformatf("%s ready j=%0d", name, j), 32'(rdy_w[sel]),
            32'((j <= rdy_lim) || (j >= s+n+e+3)));
    end
    src_valid = '0;
    check($sformatf("%s err_drop", name), 32'(err_w[sel]), 32'(mode == 2));
    if (mode == 2) begin
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      check($sformatf("%s err_clr", name), 32'(err_w[sel]), 32'd0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    err_clr   = 1'b0;
    src_valid = '0;
    src_bit   = '0;
    repeat (3) @(negedge clock);
    check("rst line", 32'(line_m), 32'h3);
    check("rst busy", 32'(busy_w), 32'h0);
    check("rst done", 32'(done_w), 32'h0);
    check("rst err", 32'(err_w), 32'h0);
    check("rst ready", 32'(rdy_w), 32'h7);
    reset_n = 1'b1;

    prep();
    run_pkt("basic", 0, 4, 64'hD, 0);
    prep();
    run_pkt("prio", 0, 5, 64'h16, 1);
    prep();
    run_pkt("deep24", 1, 24, 64'hA5C3F1, 0);
    prep();
    run_pkt("eop_err", 0, 3, 64'h5, 2);

    prep();
    cur_sel = 0;
    for (int c = 0; c < 4; c++) begin
      src_valid = 2'b01;
      src_bit   = {1'b0, c[0]};
      @(posedge clock);
      @(negedge clock);
    end
    check("rst_mid sync3", 32'(line_m), 32'h2);
    reset_n   = 1'b0;
    src_valid = '0;
    #1;
    check("rst_mid line", 32'(line_m), 32'h3);
    check("rst_mid busy", 32'(busy_w[0]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    prep();
    run_pkt("after_rst", 0, 2, 64'h2, 0);

    prep();
    run_pkt("sync32", 2, 1, 64'h1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
